sig_in_filter: RTL

SIG_IN_FILTER -- requirements
Module: sig_in_filter

---
 rtl/sig_in_filter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sig_in_filter.sv
// sig_in_filter: debounces a raw sensor pin by polling it every POLL_DIV clocks into a
// FILTER_WIDTH-sample window; out only changes when a full window is uniform.
// timeout flags a pin whose full window has stayed mixed for TIMEOUT_POLLS consecutive polls.
module sig_in_filter #(
  parameter int POLL_DIV      = 250_000,
  parameter int FILTER_WIDTH  = 8,
  parameter int TIMEOUT_POLLS = 64
) (
  input  logic clk,
  input  logic aclr,
  input  logic sclr,
  input  logic in,
  input  logic level,
  output logic out,
  output logic ready,
  output logic timeout,
  output logic tick
);

  localparam int CW  = $clog2(POLL_DIV);
  localparam int FCW = $clog2(FILTER_WIDTH + 1);
  localparam int UCW = $clog2(TIMEOUT_POLLS + 1);

  localparam logic [CW-1:0]  CNT_LAST  = CW'(POLL_DIV - 1);
  localparam logic [FCW-1:0] FILL_FULL = FCW'(FILTER_WIDTH);
  localparam logic [UCW-1:0] UNST_MAX  = UCW'(TIMEOUT_POLLS);

  logic [1:0]              sync_q;
  logic [CW-1:0]           cnt_q,  cnt_d;
  logic [FILTER_WIDTH-1:0] win_q,  win_d;
  logic [FCW-1:0]          fill_q, fill_d;
  logic [UCW-1:0]          unst_q, unst_d;
  logic                    out_q,  out_d;
  logic                    rdy_q,  rdy_d;
  logic                    to_q,   to_d;
  logic                    tick_q, tick_d;
  logic                    samp;
  logic                    win_uniform;

  // Two-flop synchronizer on the raw pin; only the hard reset clears it so a soft
  // clear never injects a false sample edge.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  // Next-state logic: prescaler, sample window, fill/unstable counters and outputs.
  always_comb begin
    cnt_d       = cnt_q;
    win_d       = win_q;
    fill_d      = fill_q;
    unst_d      = unst_q;
    out_d       = out_q;
    rdy_d       = rdy_q;
    win_uniform = 1'b0;
    // level is applied live, so a polarity change affects the very next sample.
    samp        = ~(sync_q[1] ^ level);

    if (sclr) begin
      // Soft clear outranks a coincident tick: nothing shifts or counts.
      cnt_d  = '0;
      win_d  = '0;
      fill_d = '0;
      unst_d = '0;
      out_d  = 1'b0;
      rdy_d  = 1'b0;
    end else begin
      cnt_d = tick_q ? '0 : cnt_q + CW'(1);
      if (tick_q) begin
        win_d = {win_q[FILTER_WIDTH-2:0], samp};
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FCW'(1);
        end
        win_uniform = (&win_d) | (~|win_d);
        if (win_uniform) begin
          unst_d = '0;
        end else if (fill_d == FILL_FULL && unst_q != UNST_MAX) begin
          unst_d = unst_q + UCW'(1);
        end
        // out stays 0 until the window has been completely filled once.
        if (fill_d == FILL_FULL) begin
          rdy_d = 1'b1;
          if (win_uniform) begin
            out_d = win_d[0];
          end
        end
      end
    end

    to_d   = (unst_d == UNST_MAX);
    tick_d = (cnt_d == CNT_LAST);
  end

  // State registers; tick is registered alongside the prescaler so it is glitch-free.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt_q  <= '0;
      win_q  <= '0;
      fill_q <= '0;
      unst_q <= '0;
      out_q  <= 1'b0;
      rdy_q  <= 1'b0;
      to_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      fill_q <= fill_d;
      unst_q <= unst_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
      to_q   <= to_d;
      tick_q <= tick_d;
    end
  end

  assign out     = out_q;
  assign ready   = rdy_q;
  assign timeout = to_q;
  assign tick    = tick_q;

endmodule
